// File: rtl/rgb_gray_stage_if.sv
// ============================================================================
//  Module   : rgb_gray_stage_if
//  Purpose  : Byte-stream input, luma FIFO output and control signals of the
//             RGB-to-gray stage.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface rgb_gray_stage_if;
  logic       gray_enable;
  logic [7:0] rgb_in;
  logic       rgb_valid;
  logic       pause;
  logic [7:0] gray_out;
  logic       gray_valid;
  logic       gray_ready;
  logic       gray_done;

  // Master drives the stage (controller, frame store and downstream sink).
  modport master (
    output gray_enable,
    output rgb_in,
    output rgb_valid,
    output gray_ready,
    input  pause,
    input  gray_out,
    input  gray_valid,
    input  gray_done
  );

  modport slave (
    input  gray_enable,
    input  rgb_in,
    input  rgb_valid,
    input  gray_ready,
    output pause,
    output gray_out,
    output gray_valid,
    output gray_done
  );
endinterface

`default_nettype wire

// File: rtl/rgb_gray_stage.sv
// ============================================================================
//  Module   : rgb_gray_stage
//  Purpose  : Assembles R,G,B byte triples into pixels, converts each to 8-bit
//             luma and queues results in a small FIFO with level-style pause.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rgb_gray_stage #(
  parameter int N          = 2,
  parameter int M          = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  rgb_gray_stage_if.slave  bus
);

  localparam int c_pixels = N * M;
  localparam int c_pw     = $clog2(c_pixels + 1);
  localparam int c_aw     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cw     = $clog2(FIFO_DEPTH + 1);

  localparam logic [c_pw-1:0] c_last_pix  = c_pw'(c_pixels - 1);
  localparam logic [c_cw:0]   c_pause_lvl = (c_cw + 1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [c_pw-1:0]   pix_cnt_q, pix_cnt_d;
  logic [7:0]        r_q, r_d;
  logic [7:0]        g_q, g_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [c_aw-1:0]   wr_ptr_q, rd_ptr_q;
  logic [c_cw-1:0]   count_q;

  logic              w_push;
  logic              w_pop;
  logic              w_clear;
  logic              w_fifo_empty;
  logic [15:0]       w_sum;
  logic [7:0]        w_luma;
  logic [c_cw:0]     w_level;

  // Luma uses the live byte as B so the pixel lands in the FIFO on the B edge.
  assign w_sum  = (16'd77  * {8'd0, r_q})
                + (16'd150 * {8'd0, g_q})
                + (16'd29  * {8'd0, bus.rgb_in});
  assign w_luma = 8'(w_sum >> 8);

  assign w_fifo_empty = (count_q == '0);
  assign w_pop        = !w_fifo_empty && bus.gray_ready;

  // Margin of one slot covers the byte the store may still send after pause.
  assign w_level = {1'b0, count_q} + {{c_cw{1'b0}}, (byte_cnt_q == 2'd2)};

  assign bus.pause      = (state_q == S_RUN) && (w_level >= c_pause_lvl);
  assign bus.gray_valid = !w_fifo_empty;
  assign bus.gray_out   = w_fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.gray_done  = (state_q == S_DONE);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    r_d        = r_q;
    g_d        = g_q;
    w_push     = 1'b0;
    w_clear    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.gray_enable) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (!bus.gray_enable) begin
          state_d    = S_IDLE;
          w_clear    = 1'b1;
          byte_cnt_d = 2'd0;
          pix_cnt_d  = '0;
        end else if (bus.rgb_valid) begin
          case (byte_cnt_q)
            2'd0: begin
              r_d        = bus.rgb_in;
              byte_cnt_d = 2'd1;
            end
            2'd1: begin
              g_d        = bus.rgb_in;
              byte_cnt_d = 2'd2;
            end
            default: begin
              w_push     = 1'b1;
              byte_cnt_d = 2'd0;
              if (pix_cnt_q == c_last_pix) begin
                pix_cnt_d = '0;
                state_d   = S_DRAIN;
              end else begin
                pix_cnt_d = pix_cnt_q + c_pw'(1);
              end
            end
          endcase
        end
      end

      S_DRAIN: begin
        if (!bus.gray_enable) begin
          state_d    = S_IDLE;
          w_clear    = 1'b1;
          byte_cnt_d = 2'd0;
          pix_cnt_d  = '0;
        end else if (w_fifo_empty) begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      pix_cnt_q  <= '0;
      r_q        <= 8'h00;
      g_q        <= 8'h00;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      r_q        <= r_d;
      g_q        <= g_d;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (w_clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + c_aw'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + c_aw'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + c_cw'(1);
        2'b01:   count_q <= count_q - c_cw'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_luma;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rgb_gray_stage.sv
// ============================================================================
//  Module   : tb_rgb_gray_stage
//  Purpose  : Directed and randomized bench for rgb_gray_stage against a
//             behavioural pixel/luma model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rgb_gray_stage;

  localparam int N          = 2;
  localparam int M          = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int PIXELS     = N * M;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rgb_gray_stage_if bus ();

  rgb_gray_stage #(
    .N          (N),
    .M          (M),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int         m_state;
  int         m_nbytes;
  int         m_npix;
  int         m_r;
  int         m_g;
  logic [7:0] exp_q[$];
  logic [7:0] stim_q[$];
  int         max_fill;
  int         done_seen;
  bit         m_accepted;

  function automatic logic [7:0] luma(input int r, input int g, input int b);
    return 8'((77 * r + 150 * g + 29 * b) / 256);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state  = M_IDLE;
    m_nbytes = 0;
    m_npix   = 0;
    m_r      = 0;
    m_g      = 0;
    exp_q.delete();
  endtask

  // Check current outputs, advance the model across the next edge, then step.
  task automatic tick();
    bit exp_pause;
    int lvl;
    m_accepted = 1'b0;
    lvl = exp_q.size() + ((m_nbytes == 2) ? 1 : 0);
    exp_pause = (m_state == M_RUN) && (lvl >= FIFO_DEPTH - 1);
    check("pause", {31'd0, bus.pause}, {31'd0, exp_pause});
    check("gray_valid", {31'd0, bus.gray_valid}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
    check("gray_done", {31'd0, bus.gray_done}, (m_state == M_DONE) ? 32'd1 : 32'd0);
    if (exp_q.size() == 0) check("gray_out_empty", {24'd0, bus.gray_out}, 32'd0);

    case (m_state)
      M_IDLE: if (bus.gray_enable) m_state = M_RUN;
      M_RUN, M_DRAIN: begin
        if (!bus.gray_enable) begin
          model_reset();
        end else begin
          if (m_state == M_DRAIN && exp_q.size() == 0) m_state = M_DONE;
          if (bus.gray_ready && exp_q.size() != 0) begin
            check("gray_out_data", {24'd0, bus.gray_out}, {24'd0, exp_q[0]});
            void'(exp_q.pop_front());
          end
          if (m_state == M_RUN && bus.rgb_valid) begin
            m_accepted = 1'b1;
            if (m_nbytes == 0) m_r = int'(bus.rgb_in);
            else if (m_nbytes == 1) m_g = int'(bus.rgb_in);
            else begin
              exp_q.push_back(luma(m_r, m_g, int'(bus.rgb_in)));
              m_npix++;
              if (m_npix == PIXELS) begin
                m_npix  = 0;
                m_state = M_DRAIN;
              end
            end
            m_nbytes = (m_nbytes + 1) % 3;
          end
        end
      end
      default: m_state = M_IDLE;
    endcase

    @(posedge clk);
    #1;
    if (exp_q.size() > max_fill) max_fill = exp_q.size();
    if (exp_q.size() > FIFO_DEPTH) check("fifo_overflow", exp_q.size(), FIFO_DEPTH);
    if (bus.gray_done === 1'b1) done_seen++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rgb_valid = 1'b1;
    bus.rgb_in    = b;
    tick();
    bus.rgb_valid = 1'b0;
    bus.rgb_in    = 8'($urandom);
  endtask

  task automatic fill_random(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
  endtask

  // Frame-store model: reacts to pause one cycle late, so one extra byte may follow.
  task automatic stream(input int ready_delay, input bit gaps);
    int idx = 0;
    int cyc = 0;
    bit lag = 1'b0;
    bit cur;
    while (idx < stim_q.size() && cyc < 400) begin
      cur = bus.pause;
      if (cyc >= ready_delay) bus.gray_ready = 1'b1;
      bus.rgb_valid = !lag && (!gaps || ($urandom_range(3) != 0));
      bus.rgb_in    = bus.rgb_valid ? stim_q[idx] : 8'($urandom);
      tick();
      if (m_accepted) idx++;
      lag = cur;
      cyc++;
    end
    bus.rgb_valid = 1'b0;
    bus.gray_ready = 1'b1;
    check("stream_bytes", idx, stim_q.size());
  endtask

  task automatic wait_idle();
    int n = 0;
    bus.rgb_valid  = 1'b0;
    bus.gray_ready = 1'b1;
    while (m_state != M_IDLE && n < 50) begin
      tick();
      n++;
    end
    check("frame_end_timeout", (m_state == M_IDLE) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    bus.gray_enable = 1'b0;
    bus.rgb_valid   = 1'b0;
    bus.rgb_in      = 8'h00;
    bus.gray_ready  = 1'b1;
    max_fill        = 0;
    done_seen       = 0;
    model_reset();

    #12;
    check("rst_pause", {31'd0, bus.pause}, 32'd0);
    check("rst_valid", {31'd0, bus.gray_valid}, 32'd0);
    check("rst_out", {24'd0, bus.gray_out}, 32'd0);
    check("rst_done", {31'd0, bus.gray_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed pixels, 1-cycle latency from the B byte.
    bus.gray_enable = 1'b1;
    tick();
    send_byte(8'd255); send_byte(8'd0);   send_byte(8'd0);
    check("luma_red", {24'd0, bus.gray_out}, 32'd76);
    send_byte(8'd10);  send_byte(8'd20);  send_byte(8'd30);
    check("luma_mixed", {24'd0, bus.gray_out}, 32'd18);
    send_byte(8'd255); send_byte(8'd255); send_byte(8'd255);
    check("luma_white", {24'd0, bus.gray_out}, 32'd255);
    send_byte(8'd0);   send_byte(8'd0);   send_byte(8'd0);
    check("luma_black", {24'd0, bus.gray_out}, 32'd0);
    wait_idle();
    check("done_count_f1", done_seen, 1);

    // Mid-gray then random back-to-back pixels.
    done_seen = 0;
    tick();
    send_byte(8'd128); send_byte(8'd128); send_byte(8'd128);
    check("luma_mid", {24'd0, bus.gray_out}, 32'd128);
    fill_random(9);
    stream(0, 1'b0);
    wait_idle();
    check("done_count_f2", done_seen, 1);

    // Backpressure: sink stalled while the store obeys pause.
    done_seen = 0;
    max_fill  = 0;
    bus.gray_ready = 1'b0;
    fill_random(3 * PIXELS);
    stream(30, 1'b1);
    wait_idle();
    check("fill_peak", (max_fill >= FIFO_DEPTH - 1) ? 32'd1 : 32'd0, 32'd1);
    check("done_count_bp", done_seen, 1);

    // Abort after five bytes.
    done_seen = 0;
    bus.gray_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    bus.gray_enable = 1'b0;
    tick();
    check("abort_valid", {31'd0, bus.gray_valid}, 32'd0);
    tick();
    tick();
    check("abort_no_done", done_seen, 0);
    bus.gray_enable = 1'b1;
    bus.gray_ready  = 1'b1;
    fill_random(3 * PIXELS);
    stream(0, 1'b1);
    wait_idle();
    check("done_count_abort", done_seen, 1);

    // Asynchronous reset mid-pixel with a pixel waiting in the FIFO.
    done_seen = 0;
    bus.gray_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    check("pre_rst_valid", {31'd0, bus.gray_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pause", {31'd0, bus.pause}, 32'd0);
    check("arst_valid", {31'd0, bus.gray_valid}, 32'd0);
    check("arst_out", {24'd0, bus.gray_out}, 32'd0);
    check("arst_done", {31'd0, bus.gray_done}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.gray_ready = 1'b1;
    tick();
    fill_random(3 * PIXELS);
    stream(0, 1'b1);
    wait_idle();
    check("done_count_rst", done_seen, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rgb_gray_stage.md
Name: rgb_gray_stage

Overview:
- Downstream neighbour of the RGB frame store. Consumes the store's byte stream (R, G, B per pixel, in that order) and assembles each 3-byte group into one pixel.
- Converts each pixel to 8-bit luma and buffers results in a small output FIFO for the next stage.
- Throttles the frame store with a level-style `pause` signal so no byte is ever lost.
- Reports frame completion to the controller.

Parameters:
- N, 2, image height in pixels
- M, 2, image width in pixels
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥ 2)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- gray_enable  input  1  controller start/hold; low aborts the frame
- rgb_in  input  8  byte from frame store
- rgb_valid  input  1  rgb_in carries a byte this cycle
- pause  output  1  request frame store to stop supplying bytes
- gray_out  output  8  luma of FIFO head pixel
- gray_valid  output  1  FIFO non-empty
- gray_ready  input  1  downstream accepts gray_out this cycle
- gray_done  output  1  one-cycle pulse: all N*M pixels delivered

Behaviour:
- Reset values (async, rst_n low): state IDLE, byte_cnt 0, pix_cnt 0, FIFO empty, R/G holding registers 0, pause 0, gray_valid 0, gray_out 8'h00, gray_done 0.
- States and transitions:
  - IDLE: rgb_in ignored.
    - → RUN when gray_enable=1.
  - RUN: accept every byte with rgb_valid=1, regardless of pause.
    - byte_cnt 0 → latch R; 1 → latch G; 2 → compute luma with the current rgb_in as B, push to FIFO, byte_cnt returns to 0, pix_cnt increments.
    - → DRAIN when the N*M-th pixel is pushed.
  - DRAIN: rgb_in ignored.
    - → DONE when the FIFO is empty.
  - DONE: gray_done=1 for exactly this one cycle.
    - → IDLE unconditionally.
- Arithmetic:
  - sum = 77·R + 150·G + 29·B, 16-bit unsigned; max is 65280, so no overflow.
  - luma = sum[15:8], truncated, no rounding.
  - Computed combinationally in the B cycle and registered into the FIFO. Latency from B byte to gray_valid is 1 cycle when the FIFO was empty.
- FIFO:
  - Pop occurs when gray_valid && gray_ready. gray_out is the head entry, or 8'h00 when empty.
  - Push and pop in the same cycle leave the count unchanged.
  - Push when full cannot occur by construction. The bench asserts this.
- pause:
  - Combinational: pause = (state==RUN) && (fifo_count + (byte_cnt==2) ≥ FIFO_DEPTH−1).
  - The frame store may deliver one more byte after pause rises. That byte is accepted; it can complete at most one pixel, and that pixel still fits.
  - pause=0 in IDLE, DRAIN and DONE.
- Byte count: bytes beyond 3·N·M in RUN cannot occur, because the state leaves RUN on the last pixel. Bytes arriving in DRAIN are dropped.
- gray_enable low in RUN or DRAIN:
  - Abort next cycle to IDLE.
  - Clear byte_cnt, pix_cnt and FIFO.
  - No gray_done.
- gray_enable low during DONE has no effect; the pulse completes.
- rst_n asserted mid-frame: all state returns to reset values immediately. Partial pixel and FIFO contents are discarded.
- rgb_valid=1 in the same cycle as the IDLE→RUN transition: the byte is ignored. The first accepted byte is in the first RUN cycle.

Test Plan:
- Single pixel, FIFO_DEPTH=4, gray_ready=1:
  - Pixel (255,0,0) → gray_out=76 one cycle after B.
  - Pixel (10,20,30) → gray_out=18.
- Extremes:
  - (255,255,255) → 255.
  - (0,0,0) → 0.
  - (128,128,128) → 128.
- Full frame N=M=2, 12 back-to-back bytes, gray_ready=1:
  - 4 lumas output in order.
  - gray_done pulses once, one cycle after the FIFO empties.
  - Afterwards state is IDLE.
- Backpressure, gray_ready=0:
  - pause rises when fifo_count=3, or when fifo_count=2 with byte_cnt=2.
  - One extra byte is delivered after pause; the FIFO reaches at most 4 entries and never overflows.
  - Raising gray_ready drains all pixels in order, with values matching the golden model.
- Abort:
  - Drop gray_enable after 5 bytes → next cycle IDLE, FIFO empty, gray_valid=0, no gray_done.
  - A new frame then processes correctly from R.
- Reset:
  - Assert rst_n low mid-pixel (byte_cnt=1), asynchronous to clk → all outputs go to reset values immediately.
  - A following frame is correct.
